// File: rtl/stopwatch_display_scan_if.sv
// stopwatch_display_scan_if: BCD digit bus from the stopwatch plus the multiplexed display pins
// master = stopwatch/board side (drives digits, page, freeze_req); slave = display scanner.
// Digits: small_sec0/1 (hundredths), sec0/1, min0/1, all BCD 4-bit.
// Display: digit_an (active-low anodes, bit 0 rightmost), seg {g..a} active-low, dp active-low, frozen.
interface stopwatch_display_scan_if;
  logic [3:0] small_sec0, small_sec1, sec0, sec1, min0, min1;
  logic       page, freeze_req, frozen, dp;
  logic [3:0] digit_an;
  logic [6:0] seg;
  modport master (
    output small_sec0, small_sec1, sec0, sec1, min0, min1, page, freeze_req,
    input  frozen, digit_an, seg, dp
  );
  modport slave (
    input  small_sec0, small_sec1, sec0, sec1, min0, min1, page, freeze_req,
    output frozen, digit_an, seg, dp
  );
endinterface

// File: rtl/stopwatch_display_scan.sv
// stopwatch_display_scan: 4-digit common-anode seven-segment scanner for the stopwatch BCD bus
// Ports: clk, rst_n (async active-low), bus (stopwatch_display_scan_if.slave: six BCD digits,
// page, freeze_req in; frozen, digit_an, seg, dp out). REFRESH_DIV = clk cycles per digit slot.
// Optional LEADING_ZERO_BLANK_EN: blanks the leftmost digit when it is 0.
module stopwatch_display_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input logic clk,
  input logic rst_n,
  stopwatch_display_scan_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  typedef enum logic {RUN, HOLD} state_t;
  state_t      state, state_nx;
  logic [PW-1:0] pre;
  logic [1:0]  scan;
  logic        tick, frame_end, load, page_q, blank;
  logic [23:0] snap, live;
  logic [15:0] shown;
  logic [3:0]  digit;
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'b0111111;
    endcase
  endfunction
  assign tick      = pre == PW'(REFRESH_DIV - 1);
  assign frame_end = tick && scan == 2'd3;
  assign live      = {bus.min1, bus.min0, bus.sec1, bus.sec0, bus.small_sec1, bus.small_sec0};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pre <= '0;
    else pre <= tick ? '0 : pre + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) scan <= 2'd0;
    else if (tick) scan <= scan + 2'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_nx;
  always_comb state_nx = bus.freeze_req ? (state == RUN ? HOLD : RUN) : state;
  // A freeze request in RUN captures the lap immediately; otherwise reload once per frame.
  always_comb begin
    bus.frozen = state == HOLD;
    load       = state == RUN && (bus.freeze_req || frame_end);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) snap <= '0;
    else if (load) snap <= live;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) page_q <= 1'b0;
    else if (frame_end) page_q <= bus.page;
  // shown holds d3..d0 for the active page, d3 in the top nibble.
  always_comb begin
    shown = page_q ? snap[15:0] : snap[23:8];
    digit = shown[{scan, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    blank = scan == 2'd3 && shown[15:12] == 4'd0;
`else
    blank = 1'b0;
`endif
  end
  // Outputs follow the scan counter one cycle later so anode, segments and dp switch together.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.digit_an <= 4'b1110;
      bus.seg      <= 7'b1000000;
      bus.dp       <= 1'b1;
    end else begin
      bus.digit_an <= ~(4'b0001 << scan);
      bus.seg      <= blank ? 7'b1111111 : seg7(digit);
      bus.dp       <= scan != 2'd2;
    end
endmodule

// File: tb/tb_stopwatch_display_scan.sv
// tb_stopwatch_display_scan: randomized check of the display scanner against a frame-level model
module tb_stopwatch_display_scan;
  localparam int DIV = 4;
  localparam logic [6:0] TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [12:0] RST_OUT = {1'b0, 4'b1110, 7'b1000000, 1'b1};
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  stopwatch_display_scan_if bus();
  stopwatch_display_scan #(.REFRESH_DIV(DIV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  int m_cnt, s;
  logic [23:0] m_snap;
  logic m_page, m_frozen, fe;
  logic [15:0] sh;
  logic [3:0] v;
  logic [6:0] sg;
  logic [12:0] exp_out;
  wire [12:0] act = {bus.frozen, bus.digit_an, bus.seg, bus.dp};
  wire [23:0] live = {bus.min1, bus.min0, bus.sec1, bus.sec0, bus.small_sec1, bus.small_sec0};
  // Model: cycles since reset give the slot; outputs show the slot/frame state before each edge.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_cnt = 0; m_snap = '0; m_page = 0; m_frozen = 0; exp_out = RST_OUT;
    end else begin
      s  = (m_cnt / DIV) % 4;
      sh = m_page ? m_snap[15:0] : m_snap[23:8];
      v  = sh[s*4 +: 4];
      sg = v < 10 ? TAB[v] : 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
      if (s == 3 && v == 0) sg = 7'b1111111;
`endif
      fe = (m_cnt % (4*DIV)) == 4*DIV - 1;
      if (bus.freeze_req) begin
        if (!m_frozen) m_snap = live;
        m_frozen = !m_frozen;
      end else if (fe && !m_frozen) m_snap = live;
      if (fe) m_page = bus.page;
      m_cnt++;
      exp_out = {m_frozen, ~(4'b0001 << s), sg, s != 2};
    end
  task automatic cycle();
    @(posedge clk); #1;
  endtask
  task automatic set_time(input int mn, input int sc, input int cs);
    bus.min1 = 4'(mn / 10); bus.min0 = 4'(mn % 10);
    bus.sec1 = 4'(sc / 10); bus.sec0 = 4'(sc % 10);
    bus.small_sec1 = 4'(cs / 10); bus.small_sec0 = 4'(cs % 10);
  endtask
  task automatic test_reset();
    #3 rst_n = 1'b0;
    #2;
    checks++;
    if (act !== RST_OUT) begin errors++; $display("FAIL reset_async act=%b exp=%b", act, RST_OUT); end
    cycle(); cycle();
    checks++;
    if (act !== RST_OUT) begin errors++; $display("FAIL reset_held act=%b exp=%b", act, RST_OUT); end
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      checks++;
      if (act !== exp_out) begin errors++; $display("FAIL reset_scan cyc=%0d act=%b exp=%b", i, act, exp_out); end
      if (i == 4 || i == 5) begin
        checks++;
        if (bus.digit_an !== (i == 4 ? 4'b1110 : 4'b1101)) begin
          errors++; $display("FAIL first_change cyc=%0d an=%b", i, bus.digit_an);
        end
      end
    end
  endtask
  task automatic test_pages();
    logic [6:0] want;
    set_time(12, 34, 56); bus.page = 0;
    for (int i = 0; i < 48; i++) begin
      cycle();
      checks++;
      if (act !== exp_out) begin errors++; $display("FAIL page0 act=%b exp=%b", act, exp_out); end
      if (i >= 32) begin
        want = bus.digit_an == 4'b0111 ? 7'b1111001 : bus.digit_an == 4'b1011 ? 7'b0100100 :
               bus.digit_an == 4'b1101 ? 7'b0110000 : 7'b0011001;
        checks++;
        if (bus.seg !== want) begin errors++; $display("FAIL page0_seg an=%b seg=%b exp=%b", bus.digit_an, bus.seg, want); end
      end
    end
    for (int i = 0; i < 20 && bus.digit_an !== 4'b1011; i++) cycle();
    bus.page = 1;
    for (int i = 0; i < 48; i++) begin
      cycle();
      checks++;
      if (act !== exp_out) begin errors++; $display("FAIL page1 act=%b exp=%b", act, exp_out); end
      if (i >= 32) begin
        want = bus.digit_an == 4'b0111 ? 7'b0110000 : bus.digit_an == 4'b1011 ? 7'b0011001 :
               bus.digit_an == 4'b1101 ? 7'b0010010 : 7'b0000010;
        checks++;
        if (bus.seg !== want) begin errors++; $display("FAIL page1_seg an=%b seg=%b exp=%b", bus.digit_an, bus.seg, want); end
      end
    end
  endtask
  task automatic test_freeze();
    logic [6:0] want;
    bus.page = 0; set_time(1, 42, 7);
    for (int i = 0; i < 40; i++) cycle();
    bus.freeze_req = 1; cycle(); bus.freeze_req = 0;
    checks++;
    if (bus.frozen !== 1'b1) begin errors++; $display("FAIL freeze_set frozen=%b exp=1", bus.frozen); end
    for (int i = 0; i < 10*4*DIV; i++) begin
      set_time($urandom_range(0, 59), $urandom_range(0, 59), $urandom_range(0, 99));
      cycle();
      want = bus.digit_an == 4'b0111 ? 7'b1000000 : bus.digit_an == 4'b1011 ? 7'b1111001 :
             bus.digit_an == 4'b1101 ? 7'b0011001 : 7'b0100100;
      checks++;
      if (act !== exp_out || bus.seg !== want) begin
        errors++; $display("FAIL freeze_hold act=%b exp=%b seg_exp=%b", act, exp_out, want);
      end
    end
    set_time(5, 59, 0);
    bus.freeze_req = 1; cycle(); bus.freeze_req = 0;
    checks++;
    if (bus.frozen !== 1'b0) begin errors++; $display("FAIL freeze_clr frozen=%b exp=0", bus.frozen); end
    for (int i = 0; i < 2*4*DIV; i++) begin
      cycle();
      checks++;
      if (act !== exp_out) begin errors++; $display("FAIL freeze_release act=%b exp=%b", act, exp_out); end
      if (bus.digit_an == 4'b1110 && i >= 4*DIV) begin
        checks++;
        if (bus.seg !== 7'b0010000) begin errors++; $display("FAIL release_value seg=%b exp=0010000", bus.seg); end
      end
    end
  endtask
  task automatic test_dash_blank();
    set_time(0, 0, 0); bus.sec0 = 4'hB; bus.page = 0;
    for (int i = 0; i < 3*4*DIV; i++) begin
      cycle();
      checks++;
      if (act !== exp_out) begin errors++; $display("FAIL dash act=%b exp=%b", act, exp_out); end
      if (i >= 2*4*DIV && bus.digit_an == 4'b1110) begin
        checks++;
        if (bus.seg !== 7'b0111111) begin errors++; $display("FAIL dash_seg seg=%b exp=0111111", bus.seg); end
      end
      if (i >= 2*4*DIV && bus.digit_an == 4'b0111) begin
        checks++;
`ifdef LEADING_ZERO_BLANK_EN
        if (bus.seg !== 7'b1111111 || bus.dp !== 1'b1) begin errors++; $display("FAIL blank seg=%b dp=%b exp=1111111/1", bus.seg, bus.dp); end
`else
        if (bus.seg !== 7'b1000000) begin errors++; $display("FAIL zero seg=%b exp=1000000", bus.seg); end
`endif
      end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      bus.min1 = 4'($urandom_range(0, 15)); bus.min0 = 4'($urandom_range(0, 15));
      bus.sec1 = 4'($urandom_range(0, 15)); bus.sec0 = 4'($urandom_range(0, 15));
      bus.small_sec1 = 4'($urandom_range(0, 15)); bus.small_sec0 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) bus.page = ~bus.page;
      bus.freeze_req = $urandom_range(0, 29) == 0;
      cycle();
      checks++;
      if (act !== exp_out) begin errors++; $display("FAIL random cyc=%0d act=%b exp=%b", i, act, exp_out); end
    end
    bus.freeze_req = 0;
  endtask
  task automatic test_async_reset();
    if (!bus.frozen) begin bus.freeze_req = 1; cycle(); bus.freeze_req = 0; end
    for (int i = 0; i < 40 && bus.digit_an !== 4'b1011; i++) cycle();
    checks++;
    if (bus.digit_an !== 4'b1011) begin errors++; $display("FAIL wait_slot2 an=%b exp=1011", bus.digit_an); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (act !== RST_OUT) begin errors++; $display("FAIL midscan_reset act=%b exp=%b", act, RST_OUT); end
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      checks++;
      if (act !== exp_out) begin errors++; $display("FAIL after_reset act=%b exp=%b", act, exp_out); end
    end
  endtask
  initial begin
    bus.page = 0; bus.freeze_req = 0;
    bus.min1 = 0; bus.min0 = 0; bus.sec1 = 0; bus.sec0 = 0; bus.small_sec1 = 0; bus.small_sec0 = 0;
    test_reset();
    test_pages();
    test_freeze();
    test_dash_blank();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
